// File: rtl/encoder_pkg.sv
// Shared types and sizing helpers for bitmap_index_encoder and its priority encoder.
package encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Index width for a given bitmap width; never below one bit.
  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of vec,
// plus a flag that is high when vec has exactly one bit set.
module lsb_priority_enc #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  logic [WIDTH-1:0] lowest;

  // Two's-complement trick isolates the lowest set bit as a one-hot vector.
  assign lowest = vec & (~vec + WIDTH'(1));

  // Each index bit is the OR of the one-hot positions whose index has that bit set.
  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bit
    logic [WIDTH-1:0] sel;
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_sel
      assign sel[gj] = ((gj >> gi) & 1) != 0;
    end
    assign idx[gi] = |(lowest & sel);
  end

  assign single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/bitmap_index_encoder.sv
// Drains a bitmap into a stream of set-bit indices, lowest first, with valid/ready on both sides.
// Define ENCODER_ZERO_BEAT_EN to emit one flagged beat (out_zero) for an all-zero bitmap.
module bitmap_index_encoder
  import encoder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W-1:0] out_seq
`ifdef ENCODER_ZERO_BEAT_EN
  ,
  output logic             out_zero
`endif
);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [IDX_W-1:0] seq;
  logic [IDX_W-1:0] low_idx;
  logic             single;

  lsb_priority_enc #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_enc (
    .vec   (pend),
    .idx   (low_idx),
    .single(single)
  );

  // in_ready is held low for the whole time reset is asserted.
  assign in_ready  = resetn && (state == IDLE);
  assign out_valid = (state == DRAIN);
  assign out_idx   = low_idx;
  assign out_seq   = seq;

`ifdef ENCODER_ZERO_BEAT_EN
  logic zero_beat;

  assign out_last = single | zero_beat;
  assign out_zero = zero_beat;
`else
  assign out_last = single;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      pend  <= '0;
      seq   <= '0;
`ifdef ENCODER_ZERO_BEAT_EN
      zero_beat <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pend <= in_vec;
            seq  <= '0;
            if (in_vec != '0) begin
              state <= DRAIN;
            end
`ifdef ENCODER_ZERO_BEAT_EN
            else begin
              state     <= DRAIN;
              zero_beat <= 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          if (out_ready) begin
            // Clearing the lowest set bit is exactly clearing the bit at out_idx.
            pend <= pend & (pend - WIDTH'(1));
            seq  <= seq + IDX_W'(1);
            if (out_last) begin
              state <= IDLE;
`ifdef ENCODER_ZERO_BEAT_EN
              zero_beat <= 1'b0;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
